gpio_cfg_master: RTL

- Wishbone initiator that issues GPIO configuration transactions to an array of gpio_wb responder blocks.
- The CPU-side or boot-sequencer side presents one command per handshake: read, write, or write-with-verify of a 12-bit config word to GPIO block index N.
- The block generates single Wishbone classic cycles, waits for ack with a timeout, optionally reads back and compares, then returns a response with status.
- Sits between the boot/config sequencer and the GPIO wishbone slaves on the housekeeping bus.

---
 rtl/gpio_cfg_pkg.sv | 19 +
 rtl/gpio_cfg_master.sv | 120 ++++++++++++
 2 files changed

// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared status codes, FSM states and config-word layout for gpio_cfg_master
package gpio_cfg_pkg;
  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TIMEOUT  = 2'b01,
    ST_MISMATCH = 2'b10,
    ST_BADIDX   = 2'b11
  } status_e;
  typedef enum logic [2:0] {IDLE, WR, GAP, RD, RSP} state_e;
  localparam int CFG_W        = 12;
  localparam int CFG_OUT_VAL  = 11;
  localparam int CFG_OUT_EN   = 10;
  localparam int CFG_INP_DIS  = 9;
  localparam int CFG_PULLUP   = 1;
  localparam int CFG_PULLDOWN = 0;
  function automatic logic [31:0] cfg_word(input logic [CFG_W-1:0] d);
    return {{(32-CFG_W){1'b0}}, d};
  endfunction
endpackage

// File: rtl/gpio_cfg_master.sv
// gpio_cfg_master: Wishbone classic initiator issuing GPIO config read, write and
// write-with-verify cycles with an ack timeout and a single outstanding transaction.
module gpio_cfg_master
  import gpio_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h2100_0000,
  parameter logic [31:0] GPIO_STRIDE = 32'h0000_0100,
  parameter logic [7:0]  CFG_OFFSET  = 8'h00,
  parameter int          NUM_GPIO    = 16,
  parameter int          IDX_W       = 5,
  parameter int          TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic             cmd_verify,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [11:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [1:0]       rsp_status,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);
  localparam int CNT_W = $clog2(TIMEOUT);
  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      adr_q, adr_d;
  logic [CFG_W-1:0] data_q, data_d;
  logic             verify_q, verify_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             stb, expired;
  logic             unused_dat_hi;
  assign unused_dat_hi = ^wbm_dat_i[31:16];
  assign stb        = state_q == WR || state_q == RD;
  assign expired    = cnt_q == CNT_W'(TIMEOUT - 1);
  assign cmd_ready  = state_q == IDLE;
  assign rsp_valid  = state_q == RSP;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = status_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = state_q == WR ? cfg_word(data_q) : 32'd0;
  assign wbm_sel_o  = stb ? 4'hF : 4'h0;
  assign wbm_we_o   = state_q == WR;
  assign wbm_cyc_o  = stb;
  assign wbm_stb_o  = stb;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      status_q   <= ST_OK;
      cnt_q      <= '0;
      adr_q      <= '0;
      data_q     <= '0;
      verify_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      verify_q   <= verify_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    data_d     = data_q;
    verify_d   = verify_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        data_d   = cmd_data;
        verify_d = cmd_we && cmd_verify;
        cnt_d    = '0;
        if (32'(cmd_idx) >= 32'(NUM_GPIO)) begin
          rsp_data_d = '0;
          status_d   = ST_BADIDX;
          state_d    = RSP;
        end else begin
          adr_d   = BASE_ADR + 32'(cmd_idx) * GPIO_STRIDE + 32'(CFG_OFFSET);
          state_d = cmd_we ? WR : RD;
        end
      end
      WR, RD: begin
        cnt_d = cnt_q + 1'b1;
        // an ack in the last allowed cycle takes priority over the timeout
        if (wbm_ack_i) begin
          cnt_d      = '0;
          state_d    = (state_q == WR && verify_q) ? GAP : RSP;
          rsp_data_d = state_q == WR ? {4'd0, data_q} : wbm_dat_i[15:0];
          status_d   = (state_q == RD && verify_q && wbm_dat_i[11:0] != data_q) ? ST_MISMATCH : ST_OK;
        end else if (expired) begin
          rsp_data_d = '0;
          status_d   = ST_TIMEOUT;
          state_d    = RSP;
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = RD;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
